// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the modulo-N up/down counter
// Optional feature macro used by this family: MOD_COUNTER_SAT_EN (saturating mode)
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Loads beyond the count range are clamped to the top value so Q never leaves 0..MODULUS-1
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] modulus);
    return (val < modulus) ? val : (modulus - 32'd1);
  endfunction

  function automatic bit params_legal(input int width, input longint modulus);
    return (width >= 1) && (width <= 31) && (modulus >= 2) &&
           (modulus <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/mod_count_next.sv
// rtl/mod_count_next.sv - combinational next-state, wrap flag and terminal count
// MOD_COUNTER_SAT_EN defined: terminal count holds instead of wrapping
module mod_count_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_wrap,
  output logic             o_tc
);

  // One extra bit so MODULUS == 2**WIDTH still has a representable top value
  localparam logic [WIDTH:0] L_MAX = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH-1:0] w_load_q;

  assign w_q_ext  = {1'b0, i_q};
  assign w_load_q = WIDTH'(clamp_load(32'(i_load_val), 32'(MODULUS)));
  assign o_tc     = (i_up == DIR_UP) ? (w_q_ext == L_MAX) : (w_q_ext == '0);

  always_comb begin
    o_q_next = i_q;
    o_wrap   = 1'b0;
    if (i_load) begin
      o_q_next = w_load_q;
    end else if (i_en) begin
      if (!o_tc) begin
        o_q_next = (i_up == DIR_UP) ? WIDTH'(w_q_ext + 1'b1) : WIDTH'(w_q_ext - 1'b1);
      end
`ifdef MOD_COUNTER_SAT_EN
      else begin
        o_q_next = i_q;
      end
`else
      else begin
        o_q_next = (i_up == DIR_UP) ? '0 : WIDTH'(L_MAX);
        o_wrap   = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo-N up/down counter with load, enable and wrap pulse
// MOD_COUNTER_SAT_EN defined: saturating mode, wrap pulse never asserted
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;

  mod_count_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .i_q        (r_q),
    .i_up       (i_up),
    .i_en       (i_en),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .o_q_next   (w_q_next),
    .o_wrap     (w_wrap_next),
    .o_tc       (o_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign o_q    = r_q;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - directed self-checking bench for mod_updown_counter
// Honours MOD_COUNTER_SAT_EN when the design is built in saturating mode
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap;
  logic       en16;
  logic [3:0] q16;
  logic       tc16, wrap16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load),
    .i_load_val(load_val), .o_q(q), .o_tc(tc), .o_wrap(wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en16), .i_up(1'b1), .i_load(1'b0),
    .i_load_val(4'd0), .o_q(q16), .o_tc(tc16), .o_wrap(wrap16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_up[12];
    int wraps;
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; en16 = 1'b0;
    #12;
    check("reset_q", q, 0);
    check("reset_wrap", wrap, 0);
    check("reset_tc", tc, 0);
    rst_n = 1'b1;
    en = 1'b1;

`ifndef MOD_COUNTER_SAT_EN
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up_q", q, exp_up[i]);
      check("up_tc", tc, (i == 8) ? 1 : 0);
      check("up_wrap", wrap, (i == 9) ? 1 : 0);
    end
    repeat (5) tick();
`else
    repeat (9) tick();
    check("sat_reach_q", q, 9);
    check("sat_reach_tc", tc, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_hold_q", q, 9);
      check("sat_hold_wrap", wrap, 0);
    end
    up = 1'b0;
    #1;
    check("sat_dir_tc", tc, 0);
    tick();
    check("sat_leave_q", q, 8);
    tick();
    up = 1'b1;
`endif
    check("midcount_q", q, 7);

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_wrap", wrap, 0);
    #2;
    tick();
    check("held_rst_q", q, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_q", q, 1);

    load = 1'b1; load_val = 4'd1;
    tick();
    check("load_over_en_q", q, 1);
    check("load_over_en_wrap", wrap, 0);
    load = 1'b0; up = 1'b0;
    tick();
    check("down_q0", q, 0);
    check("down_tc", tc, 1);
    tick();
`ifndef MOD_COUNTER_SAT_EN
    check("down_wrap_q", q, 9);
    check("down_wrap_pulse", wrap, 1);
    check("down_tc9", tc, 0);
    tick();
    check("down_q8", q, 8);
    check("down_wrap_clear", wrap, 0);
`else
    check("sat_down_q", q, 0);
    check("sat_down_wrap", wrap, 0);
    up = 1'b1;
    tick();
    check("sat_down_leave_q", q, 1);
`endif

    up = 1'b1; load = 1'b1; load_val = 4'd9;
    tick();
    check("load9_q", q, 9);
    load = 1'b0;
    #1;
    check("load9_tc_up", tc, 1);
    up = 1'b0;
    #1;
    check("load9_tc_down", tc, 0);
    up = 1'b1;
    load = 1'b1; load_val = 4'd3;
    tick();
    check("load3_q", q, 3);
    check("load3_wrap", wrap, 0);
    load_val = 4'd14;
    tick();
    check("clamp14_q", q, 9);
    load_val = 4'd10;
    tick();
    check("clamp10_q", q, 9);
    load_val = 4'd0;
    tick();
    check("load0_q", q, 0);
    load = 1'b0; en = 1'b0;
    tick();
    check("hold_q", q, 0);
    check("hold_wrap", wrap, 0);

    check("full_start_q", q16, 0);
    en16 = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (wrap16) wraps++;
`ifndef MOD_COUNTER_SAT_EN
      if (k == 15) begin
        check("full_q15", q16, 15);
        check("full_tc15", tc16, 1);
      end
      if (k == 16) begin
        check("full_q16", q16, 0);
        check("full_wrap16", wrap16, 1);
      end
      if (k == 17) check("full_wrap17", wrap16, 0);
      if (k == 32) check("full_wrap32", wrap16, 1);
`else
      if (k == 20) check("sat_full_q", q16, 15);
`endif
    end
`ifndef MOD_COUNTER_SAT_EN
    check("full_wrap_count", wraps, 2);
`else
    check("sat_full_wrap_count", wraps, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous modulo-N up/down counter with parallel load, count enable and a one-cycle wrap pulse. It is the next generation of the 4-bit ripple counter: all state changes on one clock edge, with configurable width, modulus and direction. It serves as the shared divider and pulse-generator primitive for the lab designs, for example as a timebase for pulse generators, display scanning and BCD digit chains (cascade via WRAP into the next stage's EN).

## Interface
- WIDTH, default 4: counter width in bits; must be ≥ 1.
- MODULUS, default 16: count range 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2**WIDTH.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- EN  input  1  count enable.
- UP  input  1  direction: 1 counts up, 0 counts down.
- LOAD  input  1  synchronous parallel load; has priority over EN.
- LOAD_VAL  input  WIDTH  value loaded when LOAD=1.
- Q  output  WIDTH  current count.
- TC  output  1  terminal count, combinational: (UP && Q==MODULUS-1) || (!UP && Q==0).
- WRAP  output  1  registered one-cycle pulse, high in the cycle after the count wrapped.

## Operation
- Reset (RST_N=0): Q=0 and WRAP=0 immediately, independent of CLK. TC follows Q and UP.
- Rising edges are evaluated in priority order:
  - LOAD=1: Q ← LOAD_VAL if LOAD_VAL < MODULUS, else Q ← MODULUS-1 (clamp). WRAP ← 0.
  - LOAD=0, EN=1, TC=0: Q ← Q+1 (UP) or Q-1 (!UP). WRAP ← 0.
  - LOAD=0, EN=1, TC=1: Q ← 0 (UP) or MODULUS-1 (!UP). WRAP ← 1.
  - Otherwise: Q holds and WRAP ← 0.
- Arithmetic is done in WIDTH+1 bits internally, so MODULUS = 2**WIDTH does not overflow. Q never leaves 0..MODULUS-1.
- UP may change on any cycle. The new direction applies at the next edge, and TC re-evaluates combinationally.
- LOAD and EN asserted together: the load wins and no wrap pulse is produced.
- Reset released mid-count: counting restarts from 0 on the first enabled edge after RST_N rises.

## Timing
- Latency from EN/LOAD to Q is one clock edge.
- WRAP is aligned with the Q update that wrapped, so it is high for exactly the cycle in which Q shows the wrapped value.
- With EN held high, WRAP has period MODULUS cycles.
- TC is combinational from Q and UP, so it is glitch-free relative to the CLK domain only.
- For a cascade, connect WRAP of stage k to EN of stage k+1. Each stage then adds one cycle of skew, and this is accepted.

## Configuration
- MOD_COUNTER_SAT_EN undefined (default): wrap-around behaviour as described in Operation.
- MOD_COUNTER_SAT_EN defined: saturating mode.
  - With EN=1 and TC=1 the counter holds at the terminal value and WRAP stays 0; WRAP is tied low in this mode.
  - LOAD, reset and direction change behave as in the default mode. Changing UP while saturated lets the count move away from the terminal value.

## Structure
- Package counter_pkg holds:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a function for the clamped load value;
  - the parameter-legality checks (MODULUS range), used by an initial assertion.
- Sub-module mod_count_next: purely combinational. Inputs are Q, UP, EN, LOAD, LOAD_VAL; outputs are next Q, the wrap flag and TC. The top level holds only the Q and WRAP registers and the asynchronous reset.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 unless stated otherwise.
1. Reset: assert RST_N=0 mid-count at Q=7 → Q=0 and WRAP=0 without waiting for a CLK edge; after release with EN=1, Q goes 0→1 on the first edge.
2. Up wrap: EN=1, UP=1 for 12 cycles → Q runs 0..9, 0, 1. TC=1 only at Q=9. WRAP=1 only in the cycle Q=0 after 9.
3. Down wrap: load 1, then UP=0, EN=1 → Q goes 1, 0, 9, 8. TC=1 at Q=0. WRAP=1 in the cycle Q=9.
4. Load priority and clamp: at Q=9 with EN=1, LOAD=1, LOAD_VAL=3 → Q=3, WRAP=0. With LOAD_VAL=14 → Q=9.
5. Full-range modulus: WIDTH=4, MODULUS=16, EN=1 → Q counts 15→0 and WRAP pulses every 16 cycles.
6. MOD_COUNTER_SAT_EN defined: count up to 9 and hold EN=1 for 3 more cycles → Q stays 9, WRAP=0. Then UP=0 → Q goes 8.
